// File: rtl/pcs_pkg.sv
// Shared constants and types for the PCS TX path: widths, sync headers,
// the 66b block type and the gearbox header/data phase.
package pcs_pkg;
  localparam int PCS_DATA_WIDTH  = 32;
  localparam int PCS_HDR_WIDTH   = 2;
  localparam int GEARBOX_SEQ_MAX = 32;

  localparam logic [PCS_HDR_WIDTH-1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [PCS_HDR_WIDTH-1:0] SYNC_HDR_CTRL = 2'b10;

  typedef struct packed {
    logic [PCS_HDR_WIDTH-1:0]    hdr;
    logic [2*PCS_DATA_WIDTH-1:0] data;
  } pcs_block_t;

  typedef enum logic {
    PH_HDR  = 1'b0,
    PH_DATA = 1'b1
  } gb_phase_t;
endpackage

// File: rtl/pcs_tx_gearbox_if.sv
// Upstream half-word bus into the TX gearbox plus the GTY-facing word and
// status flags; master is the encoder side, slave is the gearbox.
interface pcs_tx_gearbox_if;
  import pcs_pkg::*;

  logic [PCS_DATA_WIDTH-1:0] i_data;
  logic [PCS_HDR_WIDTH-1:0]  i_hdr;
  logic                      i_hdr_valid;
  logic                      i_valid;
  logic                      o_ready;
  logic [PCS_DATA_WIDTH-1:0] o_gty_data;
  logic                      o_underflow;
  logic                      o_align_err;

  modport master (
    output i_data, i_hdr, i_hdr_valid, i_valid,
    input  o_ready, o_gty_data, o_underflow, o_align_err
  );

  modport slave (
    input  i_data, i_hdr, i_hdr_valid, i_valid,
    output o_ready, o_gty_data, o_underflow, o_align_err
  );
endinterface

// File: rtl/pcs_gearbox_seq.sv
// Free-running 0..SEQ_MAX gearbox sequence counter with a registered ready
// that drops for the single cycle the counter sits at SEQ_MAX.
module pcs_gearbox_seq import pcs_pkg::*; #(
  parameter int SEQ_MAX = GEARBOX_SEQ_MAX
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic ready
);
  localparam int SEQ_W = $clog2(SEQ_MAX + 1);

  logic [SEQ_W-1:0] seq, seq_nxt;

  always_comb begin
    seq_nxt = (seq == SEQ_W'(SEQ_MAX)) ? '0 : seq + SEQ_W'(1);
  end

  // ready tracks the seq value being loaded, so it lines up with seq itself
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      seq   <= '0;
      ready <= 1'b0;
    end else begin
      seq   <= seq_nxt;
      ready <= (seq_nxt != SEQ_W'(SEQ_MAX));
    end
  end
endmodule

// File: rtl/pcs_tx_gearbox.sv
// 66b->32b TX gearbox: packs header+lo / hi half-words into a continuous
// 32-bit LSB-first word stream for a GTY in raw 32-bit mode.
module pcs_tx_gearbox import pcs_pkg::*; #(
  parameter int DATA_WIDTH = PCS_DATA_WIDTH,
  parameter int HDR_WIDTH  = PCS_HDR_WIDTH,
  parameter int SEQ_MAX    = GEARBOX_SEQ_MAX
) (
  input  logic            i_clk,
  input  logic            i_reset,
  pcs_tx_gearbox_if.slave gb
);
  localparam int BUF_W     = 2 * DATA_WIDTH;
  localparam int APP_W     = DATA_WIDTH + HDR_WIDTH;
  localparam int CMB_W     = BUF_W + APP_W;
  localparam int CNT_W     = $clog2(BUF_W);
  localparam int CMB_CNT_W = $clog2(CMB_W) + 1;

  logic                 ready;
  logic                 accept;
  logic                 align_hit;
  logic                 underflow, align_err;
  logic [DATA_WIDTH-1:0] gty_data, gty_nxt;
  logic [BUF_W-1:0]     res_bits, res_bits_nxt;
  logic [CNT_W-1:0]     res_cnt, res_cnt_nxt;
  logic [APP_W-1:0]     app_bits;
  logic [CMB_CNT_W-1:0] app_cnt, cmb_cnt, rem_cnt;
  logic [CMB_W-1:0]     cmb_bits;
  logic [BUF_W-1:0]     rem_bits;
  gb_phase_t            phase, phase_nxt;

  pcs_gearbox_seq #(.SEQ_MAX(SEQ_MAX)) u_seq (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .ready   (ready)
  );

  // New bits land above the residual, so older bits leave on the wire first
  always_comb begin
    accept   = gb.i_valid & ready;
    app_bits = '0;
    app_cnt  = '0;
    if (accept) begin
      if (gb.i_hdr_valid) begin
        app_bits = {gb.i_data, gb.i_hdr};
        app_cnt  = CMB_CNT_W'(APP_W);
      end else begin
        app_bits = APP_W'(gb.i_data);
        app_cnt  = CMB_CNT_W'(DATA_WIDTH);
      end
    end
    cmb_bits = CMB_W'(res_bits) | (CMB_W'(app_bits) << res_cnt);
    cmb_cnt  = CMB_CNT_W'(res_cnt) + app_cnt;
    gty_nxt  = cmb_bits[DATA_WIDTH-1:0];
    rem_bits = BUF_W'(cmb_bits >> DATA_WIDTH);

    rem_cnt      = '0;
    res_bits_nxt = '0;
    res_cnt_nxt  = '0;
    if (cmb_cnt >= CMB_CNT_W'(DATA_WIDTH)) begin
      rem_cnt = cmb_cnt - CMB_CNT_W'(DATA_WIDTH);
      // Only reachable on a misaligned stream: keep the oldest word, drop the rest
      if (rem_cnt > CMB_CNT_W'(DATA_WIDTH)) begin
        res_bits_nxt = BUF_W'(rem_bits[DATA_WIDTH-1:0]);
        res_cnt_nxt  = CNT_W'(DATA_WIDTH);
      end else begin
        res_bits_nxt = rem_bits;
        res_cnt_nxt  = rem_cnt[CNT_W-1:0];
      end
    end
  end

  // Header/data phase tracker; the word is taken as presented either way
  always_comb begin
    phase_nxt = phase;
    align_hit = 1'b0;
    if (accept) begin
      align_hit = gb.i_hdr_valid ^ (phase == PH_HDR);
      phase_nxt = gb.i_hdr_valid ? PH_DATA : PH_HDR;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      phase     <= PH_HDR;
      res_bits  <= '0;
      res_cnt   <= '0;
      gty_data  <= '0;
      underflow <= 1'b0;
      align_err <= 1'b0;
    end else begin
      phase    <= phase_nxt;
      res_bits <= res_bits_nxt;
      res_cnt  <= res_cnt_nxt;
      gty_data <= gty_nxt;
      if (ready & ~gb.i_valid) underflow <= 1'b1;
      if (align_hit)           align_err <= 1'b1;
    end
  end

  assign gb.o_ready     = ready;
  assign gb.o_gty_data  = gty_data;
  assign gb.o_underflow = underflow;
  assign gb.o_align_err = align_err;
endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// Directed bench for pcs_tx_gearbox: hand-computed words at key points plus a
// serial bit-queue reference that checks every output word and flag.
module tb_pcs_tx_gearbox;
  import pcs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcs_tx_gearbox_if gb();

  pcs_tx_gearbox dut (
    .i_clk   (clk),
    .i_reset (rst),
    .gb      (gb)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference state
  bit q[$];
  int seq_m;
  bit rdy_m, uf_m, ae_m, exp_hdr_m;
  int widx;
  int mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, gb.o_gty_data, 32'h0);
    chk({tag, "_ready"}, 32'(gb.o_ready), 32'h0);
    chk({tag, "_uf"}, 32'(gb.o_underflow), 32'h0);
    chk({tag, "_ae"}, 32'(gb.o_align_err), 32'h0);
  endtask

  // One clock: drive inputs, advance reference, then sample 1 time unit after the edge
  task automatic tick(input bit v, input bit hv, input logic [1:0] hdr,
                      input logic [31:0] d, output bit acc);
    logic [31:0] w;
    gb.i_valid     = v;
    gb.i_hdr_valid = hv;
    gb.i_hdr       = hdr;
    gb.i_data      = d;
    acc = rdy_m && v;
    if (rdy_m && !v) uf_m = 1'b1;
    if (acc) begin
      if (hv != exp_hdr_m) ae_m = 1'b1;
      exp_hdr_m = !hv;
      if (hv) begin
        q.push_back(hdr[0]);
        q.push_back(hdr[1]);
      end
      for (int i = 0; i < 32; i++) q.push_back(d[i]);
    end
    w = '0;
    for (int i = 0; i < 32; i++) if (q.size() > 0) w[i] = q.pop_front();
    while (q.size() > 32) void'(q.pop_back());
    seq_m = (seq_m == 32) ? 0 : seq_m + 1;
    rdy_m = (seq_m != 32);
    @(posedge clk);
    #1;
    chk("ready", 32'(gb.o_ready), 32'(rdy_m));
    chk("gty_data", gb.o_gty_data, w);
    chk("underflow", 32'(gb.o_underflow), 32'(uf_m));
    chk("align_err", 32'(gb.o_align_err), 32'(ae_m));
    if (seq_m == 0) chk("res_after_pause", 32'(dut.res_cnt), 32'h0);
  endtask

  // Continuous upstream: holds the current word until it is accepted
  task automatic feed(input int n);
    pcs_block_t b;
    bit acc;
    for (int c = 0; c < n; c++) begin
      int k;
      k = widx / 2;
      if (mode == 0) begin
        b.hdr  = SYNC_HDR_DATA;
        b.data = {32'h5555_5555, 32'hAAAA_AAAA};
      end else begin
        b.hdr  = k[0] ? SYNC_HDR_CTRL : SYNC_HDR_DATA;
        b.data = {32'(2 * k + 1), 32'(2 * k)};
      end
      if (widx[0] == 1'b0) tick(1'b1, 1'b1, b.hdr, b.data[31:0], acc);
      else                 tick(1'b1, 1'b0, 2'b00, b.data[63:32], acc);
      if (acc) widx++;
    end
  endtask

  task automatic do_reset(input int n);
    gb.i_valid     = 1'b0;
    gb.i_hdr_valid = 1'b0;
    gb.i_hdr       = '0;
    gb.i_data      = '0;
    #2 rst = 1'b1;
    #1;
    chk_zero("rst_async");
    repeat (n) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst = 1'b0;
    q.delete();
    seq_m     = 0;
    rdy_m     = 1'b0;
    uf_m      = 1'b0;
    ae_m      = 1'b0;
    exp_hdr_m = 1'b1;
    widx      = 0;
    #1;
    chk("ready_exit", 32'(gb.o_ready), 32'h0);
  endtask

  initial begin
    bit acc;
    gb.i_valid     = 1'b0;
    gb.i_hdr_valid = 1'b0;
    gb.i_hdr       = '0;
    gb.i_data      = '0;

    // continuous AAAA/5555 blocks; stall after edges 32 and 65
    mode = 0;
    do_reset(3);
    feed(2);  chk("s1_w0", gb.o_gty_data, 32'hAAAA_AAA9);
    feed(1);  chk("s1_w1", gb.o_gty_data, 32'h5555_5556);
    feed(1);  chk("s1_w2", gb.o_gty_data, 32'hAAAA_AAA5);
    feed(28); chk("s1_stall0", 32'(gb.o_ready), 32'h0);
    feed(1);  chk("s1_resume", 32'(gb.o_ready), 32'h1);
    feed(32); chk("s1_stall1", 32'(gb.o_ready), 32'h0);
    feed(51);
    chk("s1_uf", 32'(gb.o_underflow), 32'h0);
    chk("s1_ae", 32'(gb.o_align_err), 32'h0);

    // reset at seq=17, then realign from scratch
    do_reset(2);
    feed(2);  chk("s6_realign", gb.o_gty_data, 32'hAAAA_AAA9);
    feed(8);

    // incrementing blocks across two frame wraps, holding words through stalls
    mode = 1;
    do_reset(1);
    feed(70);
    chk("s2_uf", 32'(gb.o_underflow), 32'h0);

    // one idle cycle at seq=5
    mode = 0;
    do_reset(1);
    feed(5);
    chk("s3_pre", gb.o_gty_data, 32'h5555_555A);
    tick(1'b0, 1'b0, 2'b00, 32'h0, acc);
    chk("s3_zfill", gb.o_gty_data, 32'h0000_0005);
    chk("s3_uf", 32'(gb.o_underflow), 32'h1);
    feed(6);
    chk("s3_sticky", 32'(gb.o_underflow), 32'h1);
    chk("s3_ae", 32'(gb.o_align_err), 32'h0);

    // two header words back to back
    do_reset(1);
    feed(2);
    chk("s4_ae_pre", 32'(gb.o_align_err), 32'h0);
    tick(1'b1, 1'b1, SYNC_HDR_DATA, 32'hAAAA_AAAA, acc);
    chk("s4_ae", 32'(gb.o_align_err), 32'h1);
    chk("s4_data", gb.o_gty_data, 32'hAAAA_AAA6);
    chk("s4_uf", 32'(gb.o_underflow), 32'h0);

    do_reset(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
